// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with a start/busy/done host handshake.
// Define SPI_MASTER_BURST_EN to enable hold/GAP so consecutive bytes share one ss-low frame.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FINISH,
    S_RELEASE
`ifdef SPI_MASTER_BURST_EN
    , S_GAP
`endif
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    tx_sr, tx_d;
  logic [7:0]    rx_sr, rx_d;
  logic          busy_d, done_d, ss_d, sck_d, mosi_d;
  logic [7:0]    dout_d;
  logic          phase_end;

  assign phase_end = (cnt == CNT_LAST);

`ifndef SPI_MASTER_BURST_EN
  logic unused_hold;
  assign unused_hold = hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    bit_cnt_d = bit_cnt;
    tx_d      = tx_sr;
    rx_d      = rx_sr;
    busy_d    = busy;
    done_d    = 1'b0;
    dout_d    = dout;
    ss_d      = ss;
    sck_d     = sck;
    mosi_d    = mosi;

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = din;
          ss_d    = 1'b0;
          mosi_d  = din[7];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          cnt_d     = '0;
          sck_d     = 1'b1;
          rx_d      = {rx_sr[6:0], miso};
          bit_cnt_d = bit_cnt + 3'd1;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d   = '0;
          sck_d   = 1'b0;
          mosi_d  = tx_sr[6];
          tx_d    = {tx_sr[6:0], 1'b0};
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          cnt_d = '0;
          // The 3-bit counter wraps back to zero exactly after the eighth rise.
          if (bit_cnt == 3'd0) begin
            state_d = S_FINISH;
          end else begin
            sck_d     = 1'b1;
            rx_d      = {rx_sr[6:0], miso};
            bit_cnt_d = bit_cnt + 3'd1;
            state_d   = S_HIGH;
          end
        end
      end
      S_FINISH: begin
        cnt_d  = '0;
        done_d = 1'b1;
        dout_d = rx_sr;
`ifdef SPI_MASTER_BURST_EN
        if (hold) begin
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          ss_d    = 1'b1;
          state_d = S_RELEASE;
        end
`else
        ss_d    = 1'b1;
        state_d = S_RELEASE;
`endif
      end
      S_RELEASE: begin
        if (phase_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`ifdef SPI_MASTER_BURST_EN
      S_GAP: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = din;
          mosi_d  = din[7];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else if (!hold) begin
          // Busy covers RELEASE so a start there is visibly refused, not silently lost.
          ss_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      ss      <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      tx_sr   <= tx_d;
      rx_sr   <= rx_d;
      busy    <= busy_d;
      done    <= done_d;
      dout    <= dout_d;
      ss      <= ss_d;
      sck     <= sck_d;
      mosi    <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=4 instance looped to a behavioural mode-0 slave,
// plus a CLK_DIV=8 instance with miso tied low. Burst checks follow SPI_MASTER_BURST_EN.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, hold4, busy4, done4, ss4, sck4, mosi4, miso4;
  logic [7:0] din4, dout4;
  logic       start8, hold8, busy8, done8, ss8, sck8, mosi8, miso8;
  logic [7:0] din8, dout8;

  assign miso8 = 1'b0;

  int checks = 0;
  int passed = 0;

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .din(din4), .hold(hold4),
    .busy(busy4), .done(done4), .dout(dout4),
    .ss(ss4), .sck(sck4), .mosi(mosi4), .miso(miso4)
  );

  spi_master #(.CLK_DIV(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .din(din8), .hold(hold8),
    .busy(busy8), .done(done8), .dout(dout8),
    .ss(ss8), .sck(sck8), .mosi(mosi8), .miso(miso8)
  );

  // Behavioural mode-0 slave on the CLK_DIV=4 link, evaluated on the falling clk edge.
  logic       sck_q, ss_q, slave_clr;
  logic [7:0] s_shift, s_rx;
  logic [3:0] s_bits;
  logic [2:0] s_idx;
  logic [7:0] slave_tx [8];
  logic [7:0] slave_rx [8];

  always @(negedge clk) begin
    sck_q <= sck4;
    ss_q  <= ss4;
    if (slave_clr) begin
      s_idx  <= '0;
      s_bits <= '0;
      miso4  <= 1'b0;
    end else if (ss_q && !ss4) begin
      s_bits  <= '0;
      s_shift <= slave_tx[s_idx];
      miso4   <= slave_tx[s_idx][7];
    end else if (!ss4 && !sck_q && sck4) begin
      s_rx   <= {s_rx[6:0], mosi4};
      s_bits <= s_bits + 4'd1;
      if (s_bits == 4'd7) slave_rx[s_idx] <= {s_rx[6:0], mosi4};
    end else if (!ss4 && sck_q && !sck4) begin
      if (s_bits == 4'd8) begin
        s_idx   <= s_idx + 3'd1;
        s_bits  <= '0;
        s_shift <= slave_tx[s_idx + 3'd1];
        miso4   <= slave_tx[s_idx + 3'd1][7];
      end else begin
        miso4   <= s_shift[6];
        s_shift <= {s_shift[6:0], 1'b0};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_slave();
    slave_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slave_clr = 1'b0;
  endtask

  // Returns at the falling edge just after the accepting rising edge (T0).
  task automatic start4_pulse(input logic [7:0] d);
    start4 = 1'b1;
    din4   = d;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic start8_pulse(input logic [7:0] d);
    start8 = 1'b1;
    din8   = d;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset_values();
    checks++; if (ss4 !== 1'b1)    $display("FAIL por_ss: got %b expected 1", ss4);       else passed++;
    checks++; if (sck4 !== 1'b0)   $display("FAIL por_sck: got %b expected 0", sck4);     else passed++;
    checks++; if (mosi4 !== 1'b0)  $display("FAIL por_mosi: got %b expected 0", mosi4);   else passed++;
    checks++; if (busy4 !== 1'b0)  $display("FAIL por_busy: got %b expected 0", busy4);   else passed++;
    checks++; if (done4 !== 1'b0)  $display("FAIL por_done: got %b expected 0", done4);   else passed++;
    checks++; if (dout4 !== 8'h00) $display("FAIL por_dout: got %h expected 00", dout4);  else passed++;
    checks++; if (ss8 !== 1'b1)    $display("FAIL por_ss8: got %b expected 1", ss8);      else passed++;
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic       exp_sck, prev, ss_at, busy72, busy73;
    logic [7:0] dout_at;
    int         rises, sck_bad, mosi_bad, done_at, done_cnt, k;
    d = 8'hA5;
    slave_tx[0] = 8'h3C;
    clear_slave();
    start4_pulse(d);
    checks++; if (ss4 !== 1'b0)   $display("FAIL single_ss_low: got %b expected 0", ss4);    else passed++;
    checks++; if (mosi4 !== 1'b1) $display("FAIL single_mosi0: got %b expected 1", mosi4);  else passed++;
    checks++; if (busy4 !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy4);   else passed++;
    rises = 0; sck_bad = 0; mosi_bad = 0; done_at = -1; done_cnt = 0;
    prev = 1'b0; ss_at = 1'b0; dout_at = 8'h00; busy72 = 1'b0; busy73 = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      exp_sck = (n >= 4) && (n < 68) && (((n - 4) % 8) < 4);
      if (sck4 !== exp_sck) sck_bad++;
      if (sck4 && !prev) rises++;
      if (exp_sck) begin
        k = (n - 4) / 8;
        if (mosi4 !== d[7-k]) mosi_bad++;
      end
      prev = sck4;
      if (done4) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; dout_at = dout4; ss_at = ss4; end
      end
      if (n == 72) busy72 = busy4;
      if (n == 73) busy73 = busy4;
    end
    checks++; if (done_at != 69)       $display("FAIL single_done_time: got %0d expected 69", done_at);     else passed++;
    checks++; if (done_cnt != 1)       $display("FAIL single_done_width: got %0d expected 1", done_cnt);    else passed++;
    checks++; if (dout_at !== 8'h3C)   $display("FAIL single_dout: got %h expected 3c", dout_at);          else passed++;
    checks++; if (ss_at !== 1'b1)      $display("FAIL single_ss_release: got %b expected 1", ss_at);       else passed++;
    checks++; if (rises != 8)          $display("FAIL single_sck_pulses: got %0d expected 8", rises);      else passed++;
    checks++; if (sck_bad != 0)        $display("FAIL single_sck_shape: got %0d bad cycles expected 0", sck_bad); else passed++;
    checks++; if (mosi_bad != 0)       $display("FAIL single_mosi_bits: got %0d bad cycles expected 0", mosi_bad); else passed++;
    checks++; if (busy72 !== 1'b1)     $display("FAIL single_busy72: got %b expected 1", busy72);          else passed++;
    checks++; if (busy73 !== 1'b0)     $display("FAIL single_busy73: got %b expected 0", busy73);          else passed++;
    checks++; if (slave_rx[0] !== 8'hA5) $display("FAIL single_slave_rx: got %h expected a5", slave_rx[0]); else passed++;
    checks++; if (s_idx !== 3'd1)      $display("FAIL single_slave_bytes: got %0d expected 1", s_idx);     else passed++;
  endtask

  task automatic test_reset_mid();
    int dones;
    slave_tx[1] = 8'h5A;
    start4_pulse(8'hA5);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ss4 !== 1'b1)    $display("FAIL rst_ss: got %b expected 1", ss4);      else passed++;
    checks++; if (sck4 !== 1'b0)   $display("FAIL rst_sck: got %b expected 0", sck4);    else passed++;
    checks++; if (mosi4 !== 1'b0)  $display("FAIL rst_mosi: got %b expected 0", mosi4);  else passed++;
    checks++; if (busy4 !== 1'b0)  $display("FAIL rst_busy: got %b expected 0", busy4);  else passed++;
    checks++; if (done4 !== 1'b0)  $display("FAIL rst_done: got %b expected 0", done4);  else passed++;
    checks++; if (dout4 !== 8'h00) $display("FAIL rst_dout: got %h expected 00", dout4); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done4 || busy4) dones++;
    end
    checks++; if (dones != 0) $display("FAIL rst_no_done: got %0d active cycles expected 0", dones); else passed++;
  endtask

  task automatic test_busy_ignore();
    int         done_cnt, done_at;
    logic [7:0] dout_at;
    slave_tx[0] = 8'h96;
    slave_tx[1] = 8'h42;
    clear_slave();
    start4_pulse(8'h0F);
    done_cnt = 0; dout_at = 8'h00;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (done4) begin done_cnt++; dout_at = dout4; end
      if (n == 10 || n == 40) begin start4 = 1'b1; din4 = 8'hFF; end
      else start4 = 1'b0;
    end
    start4 = 1'b0;
    checks++; if (done_cnt != 1)          $display("FAIL ign_done_count: got %0d expected 1", done_cnt);  else passed++;
    checks++; if (dout_at !== 8'h96)      $display("FAIL ign_dout: got %h expected 96", dout_at);          else passed++;
    checks++; if (slave_rx[0] !== 8'h0F)  $display("FAIL ign_slave_rx: got %h expected 0f", slave_rx[0]); else passed++;
    checks++; if (busy4 !== 1'b0)         $display("FAIL ign_not_queued: got %b expected 0", busy4);      else passed++;
    start4_pulse(8'h81);
    done_at = -1; dout_at = 8'h00;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (done4 && done_at < 0) begin done_at = n; dout_at = dout4; end
    end
    checks++; if (done_at != 69)          $display("FAIL ign_next_time: got %0d expected 69", done_at);   else passed++;
    checks++; if (dout_at !== 8'h42)      $display("FAIL ign_next_dout: got %h expected 42", dout_at);    else passed++;
    checks++; if (slave_rx[1] !== 8'h81)  $display("FAIL ign_next_slave: got %h expected 81", slave_rx[1]); else passed++;
  endtask

  task automatic test_div8();
    logic       prev, mosi_at_done, ss_at_done;
    logic [7:0] dout_at;
    int         rises, rises_hi, done_at;
    start8_pulse(8'hFF);
    prev = 1'b0; rises = 0; rises_hi = 0; done_at = -1;
    dout_at = 8'hFF; mosi_at_done = 1'b1; ss_at_done = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (sck8 && !prev) begin
        rises++;
        if (mosi8 === 1'b1) rises_hi++;
      end
      prev = sck8;
      if (done8 && done_at < 0) begin
        done_at = n; dout_at = dout8; mosi_at_done = mosi8; ss_at_done = ss8;
      end
    end
    checks++; if (done_at != 137)        $display("FAIL div8_done_time: got %0d expected 137", done_at); else passed++;
    checks++; if (dout_at !== 8'h00)     $display("FAIL div8_dout: got %h expected 00", dout_at);        else passed++;
    checks++; if (rises != 8)            $display("FAIL div8_pulses: got %0d expected 8", rises);        else passed++;
    checks++; if (rises_hi != 8)         $display("FAIL div8_mosi_high: got %0d expected 8", rises_hi);  else passed++;
    checks++; if (mosi_at_done !== 1'b0) $display("FAIL div8_mosi_final: got %b expected 0", mosi_at_done); else passed++;
    checks++; if (ss_at_done !== 1'b1)   $display("FAIL div8_ss: got %b expected 1", ss_at_done);       else passed++;
    checks++; if (busy8 !== 1'b0)        $display("FAIL div8_busy_end: got %b expected 0", busy8);      else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    int         ss_high, dones, guard;
    logic       seen;
    slave_tx[0] = 8'hAB;
    slave_tx[1] = 8'hCD;
    clear_slave();
    hold4 = 1'b1;
    d1 = 8'h00; d2 = 8'h00; ss_high = 0; dones = 0;
    start4_pulse(8'h12);
    seen = 1'b0; guard = 0;
    while (!seen && guard < 80) begin
      guard++;
      @(negedge clk);
      if (done4) begin seen = 1'b1; d1 = dout4; dones++; end
    end
`ifdef SPI_MASTER_BURST_EN
    checks++; if (ss4 !== 1'b0)  $display("FAIL burst_ss_gap: got %b expected 0", ss4);    else passed++;
    checks++; if (busy4 !== 1'b0) $display("FAIL burst_busy_gap: got %b expected 0", busy4); else passed++;
    start4_pulse(8'h34);
    seen = 1'b0; guard = 0;
    while (!seen && guard < 80) begin
      guard++;
      @(negedge clk);
      if (ss4) ss_high++;
      if (done4) begin seen = 1'b1; d2 = dout4; dones++; end
    end
    @(negedge clk);
    checks++; if (ss4 !== 1'b0)  $display("FAIL burst_ss_hold: got %b expected 0", ss4);   else passed++;
    hold4 = 1'b0;
    @(negedge clk);
    checks++; if (ss4 !== 1'b1)  $display("FAIL burst_ss_drop: got %b expected 1", ss4);   else passed++;
    checks++; if (ss_high != 0)  $display("FAIL burst_ss_frame: got %0d high cycles expected 0", ss_high); else passed++;
`else
    seen = 1'b0; guard = 0;
    while (!seen && guard < 20) begin
      guard++;
      if (ss4) ss_high++;
      if (!busy4) seen = 1'b1;
      else @(negedge clk);
    end
    start4_pulse(8'h34);
    seen = 1'b0; guard = 0;
    while (!seen && guard < 80) begin
      guard++;
      @(negedge clk);
      if (done4) begin seen = 1'b1; d2 = dout4; dones++; end
    end
    hold4 = 1'b0;
    checks++; if (ss_high < 4)   $display("FAIL b2b_ss_gap: got %0d high cycles expected >=4", ss_high); else passed++;
`endif
    repeat (20) @(negedge clk);
    checks++; if (busy4 !== 1'b0)         $display("FAIL b2b_busy_end: got %b expected 0", busy4);     else passed++;
    checks++; if (dones != 2)             $display("FAIL b2b_done_count: got %0d expected 2", dones);  else passed++;
    checks++; if (d1 !== 8'hAB)           $display("FAIL b2b_dout1: got %h expected ab", d1);          else passed++;
    checks++; if (d2 !== 8'hCD)           $display("FAIL b2b_dout2: got %h expected cd", d2);          else passed++;
    checks++; if (slave_rx[0] !== 8'h12)  $display("FAIL b2b_slave1: got %h expected 12", slave_rx[0]); else passed++;
    checks++; if (slave_rx[1] !== 8'h34)  $display("FAIL b2b_slave2: got %h expected 34", slave_rx[1]); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; din4 = 8'h00; hold4 = 1'b0;
    start8 = 1'b0; din8 = 8'h00; hold8 = 1'b0;
    slave_clr = 1'b1;
    repeat (3) @(negedge clk);
    test_reset_values();
    rst = 1'b0;
    slave_clr = 1'b0;
    @(negedge clk);
    test_single();
    test_reset_mid();
    test_busy_ignore();
    test_div8();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
